// File: rtl/prefix_strip_queue_if.sv
// Handshake bundle between the instruction-byte queue, the prefix stripper
// and the downstream length decoder.
// Optional feature macro: PREFIX_LOCK_EN adds the isLOCK summary bit.
interface prefix_strip_queue_if #(
  parameter int CNT_W = 4
);
  logic [23:0]      win;
  logic [2:0]       win_valid;
  logic             pop;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             insn_done;
  logic [7:0]       B1;
  logic [7:0]       B2;
  logic [7:0]       B3;
  logic             isREP;
  logic             isSIZE;
  logic             isSEG;
  logic [5:0]       segSEL;
  logic [CNT_W-1:0] prefSize;
  logic             pref_err;
`ifdef PREFIX_LOCK_EN
  logic             isLOCK;
`endif

  // Stripper side
  modport slave (
    input  win, win_valid, flush, out_ready, insn_done,
    output pop,
`ifdef PREFIX_LOCK_EN
    output isLOCK,
`endif
    output out_valid, B1, B2, B3, isREP, isSIZE, isSEG, segSEL, prefSize, pref_err
  );

  // Queue / decoder side
  modport master (
    output win, win_valid, flush, out_ready, insn_done,
    input  pop,
`ifdef PREFIX_LOCK_EN
    input  isLOCK,
`endif
    input  out_valid, B1, B2, B3, isREP, isSIZE, isSEG, segSEL, prefSize, pref_err
  );
endinterface

// File: rtl/prefix_strip_queue.sv
// Prefix stripper in front of the control-store overwrite stage: pops x86
// prefix bytes off the queue head, then snapshots the three opcode/ModRM
// bytes together with a prefix summary and offers them downstream.
// Optional feature macro: PREFIX_LOCK_EN (0xF0 treated as a prefix, isLOCK).
//
//   state | meaning
//   PFX   | consuming prefix bytes, waiting for a full 3-byte window
//   HOLD  | snapshot presented, waiting for out_ready
//   WAIT  | snapshot taken, waiting for insn_done from the length decoder
module prefix_strip_queue #(
  parameter int MAX_PFX = 4,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  prefix_strip_queue_if.slave   bus
);

  typedef enum logic [1:0] {PFX, HOLD, WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_PFX);

  state_t           state, state_nxt;
  logic             pop_c, capture, clear;
  logic [7:0]       b0;
  logic [5:0]       seg_oh;
  logic [CNT_W-1:0] cnt_inc;

  logic [7:0]       b1_q, b2_q, b3_q;
  logic             rep_q, size_q, seg_q, err_q;
  logic [5:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
`ifdef PREFIX_LOCK_EN
  logic             lock_q;
`endif

  function automatic logic is_prefix(input logic [7:0] b);
    case (b)
      8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'hF3: is_prefix = 1'b1;
`ifdef PREFIX_LOCK_EN
      8'hF0:                                                  is_prefix = 1'b1;
`endif
      default:                                                is_prefix = 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] seg_onehot(input logic [7:0] b);
    case (b)
      8'h26:   seg_onehot = 6'b000001;
      8'h2E:   seg_onehot = 6'b000010;
      8'h36:   seg_onehot = 6'b000100;
      8'h3E:   seg_onehot = 6'b001000;
      8'h64:   seg_onehot = 6'b010000;
      8'h65:   seg_onehot = 6'b100000;
      default: seg_onehot = 6'b000000;
    endcase
  endfunction

  assign b0      = bus.win[7:0];
  assign seg_oh  = seg_onehot(b0);
  // prefSize sticks at all-ones rather than wrapping on absurd prefix runs
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Next-state and per-cycle strobes; flush overrides everything
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    capture   = 1'b0;
    clear     = 1'b0;
    if (bus.flush) begin
      state_nxt = PFX;
      clear     = 1'b1;
    end else begin
      case (state)
        PFX: begin
          if (bus.win_valid[0] && is_prefix(b0)) begin
            pop_c = 1'b1;
          end else if (bus.win_valid == 3'b111) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) state_nxt = WAIT;
        end
        WAIT: begin
          if (bus.insn_done) begin
            clear     = 1'b1;
            state_nxt = PFX;
          end
        end
        default: state_nxt = PFX;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PFX;
    else     state <= state_nxt;
  end

  // Opcode snapshot; left untouched while prefixes are being stripped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b1_q <= 8'h00;
      b2_q <= 8'h00;
      b3_q <= 8'h00;
    end else if (capture) begin
      b1_q <= bus.win[7:0];
      b2_q <= bus.win[15:8];
      b3_q <= bus.win[23:16];
    end
  end

  // Prefix summary accumulation; pref_err is sticky but popping carries on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q  <= 1'b0;
      size_q <= 1'b0;
      seg_q  <= 1'b0;
      sel_q  <= 6'b000000;
      cnt_q  <= '0;
      err_q  <= 1'b0;
`ifdef PREFIX_LOCK_EN
      lock_q <= 1'b0;
`endif
    end else if (clear) begin
      rep_q  <= 1'b0;
      size_q <= 1'b0;
      seg_q  <= 1'b0;
      sel_q  <= 6'b000000;
      cnt_q  <= '0;
      err_q  <= 1'b0;
`ifdef PREFIX_LOCK_EN
      lock_q <= 1'b0;
`endif
    end else if (pop_c) begin
      if (b0 == 8'hF3) rep_q  <= 1'b1;
      if (b0 == 8'h66) size_q <= 1'b1;
      if (seg_oh != 6'b000000) begin
        seg_q <= 1'b1;
        sel_q <= seg_oh;
      end
`ifdef PREFIX_LOCK_EN
      if (b0 == 8'hF0) lock_q <= 1'b1;
`endif
      cnt_q <= cnt_inc;
      if (cnt_inc > CNT_LIM) err_q <= 1'b1;
    end
  end

  // pop is held low during reset so the queue never loses a byte then
  assign bus.pop       = pop_c & ~rst;
  assign bus.out_valid = (state == HOLD);
  assign bus.B1        = b1_q;
  assign bus.B2        = b2_q;
  assign bus.B3        = b3_q;
  assign bus.isREP     = rep_q;
  assign bus.isSIZE    = size_q;
  assign bus.isSEG     = seg_q;
  assign bus.segSEL    = sel_q;
  assign bus.prefSize  = cnt_q;
  assign bus.pref_err  = err_q;
`ifdef PREFIX_LOCK_EN
  assign bus.isLOCK    = lock_q;
`endif

endmodule

// File: tb/tb_prefix_strip_queue.sv
// Bench for prefix_strip_queue: byte-queue model feeding the window, expected
// snapshot derived per instruction from its prefix list.
// Optional feature macro: PREFIX_LOCK_EN.
module tb_prefix_strip_queue;
  localparam int MAX_PFX = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prefix_strip_queue_if #(.CNT_W(CNT_W)) bus();
  prefix_strip_queue #(.MAX_PFX(MAX_PFX), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic [7:0] cur_pfx[$];
  logic [7:0] cur_ops[3];
  logic [7:0] pfx_tab[$];
  int         avail;

  logic       exp_rep, exp_size, exp_seg, exp_err, exp_lock;
  logic [5:0] exp_sel;
  int         exp_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_is_pfx(input logic [7:0] b);
`ifdef PREFIX_LOCK_EN
    return b inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'hF3, 8'hF0};
`else
    return b inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'hF3};
`endif
  endfunction

  function automatic logic [5:0] ref_seg(input logic [7:0] b);
    case (b)
      8'h26:   return 6'b000001;
      8'h2E:   return 6'b000010;
      8'h36:   return 6'b000100;
      8'h3E:   return 6'b001000;
      8'h64:   return 6'b010000;
      8'h65:   return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  // Whole-instruction view of the summary the stripper should present
  task automatic set_expect();
    exp_rep = 0; exp_size = 0; exp_seg = 0; exp_lock = 0; exp_sel = 6'b0;
    foreach (cur_pfx[i]) begin
      if (cur_pfx[i] == 8'hF3) exp_rep = 1;
      if (cur_pfx[i] == 8'h66) exp_size = 1;
      if (cur_pfx[i] == 8'hF0) exp_lock = 1;
      if (ref_seg(cur_pfx[i]) != 6'b0) begin
        exp_seg = 1;
        exp_sel = ref_seg(cur_pfx[i]);
      end
    end
    exp_cnt = (cur_pfx.size() > CNT_SAT) ? CNT_SAT : cur_pfx.size();
    exp_err = (cur_pfx.size() > MAX_PFX);
  endtask

  task automatic drive_inputs();
    logic [23:0] w;
    logic [2:0]  v;
    w = 24'h0;
    v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (i < avail && i < q.size()) begin
        w[i*8 +: 8] = q[i];
        v[i] = 1'b1;
      end else begin
        w[i*8 +: 8] = 8'($urandom);
      end
    end
    bus.win       = w;
    bus.win_valid = v;
  endtask

  task automatic check_summary();
    check_val("snap_out_valid", bus.out_valid, 1);
    check_val("snap_B1", bus.B1, cur_ops[0]);
    check_val("snap_B2", bus.B2, cur_ops[1]);
    check_val("snap_B3", bus.B3, cur_ops[2]);
    check_val("snap_isREP", bus.isREP, exp_rep);
    check_val("snap_isSIZE", bus.isSIZE, exp_size);
    check_val("snap_isSEG", bus.isSEG, exp_seg);
    check_val("snap_segSEL", bus.segSEL, exp_sel);
    check_val("snap_prefSize", bus.prefSize, exp_cnt);
    check_val("snap_pref_err", bus.pref_err, exp_err);
`ifdef PREFIX_LOCK_EN
    check_val("snap_isLOCK", bus.isLOCK, exp_lock);
`endif
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_out_valid"}, bus.out_valid, 0);
    check_val({tag, "_prefSize"}, bus.prefSize, 0);
    check_val({tag, "_flags"}, {bus.isREP, bus.isSIZE, bus.isSEG, bus.pref_err}, 0);
    check_val({tag, "_segSEL"}, bus.segSEL, 0);
`ifdef PREFIX_LOCK_EN
    check_val({tag, "_isLOCK"}, bus.isLOCK, 0);
`endif
  endtask

  // Feeds one instruction from the queue until the stripper captures it
  task automatic present_insn(input int stall, input bit rnd, output int cycles);
    int   pops;
    bit   cap, exp_pop;
    logic got_pop;
    pops = 0; cap = 0; cycles = 0;
    set_expect();
    foreach (cur_pfx[i]) q.push_back(cur_pfx[i]);
    for (int i = 0; i < 3; i++) q.push_back(cur_ops[i]);
    while (!cap && cycles < 200) begin
      if (rnd) begin
        avail = $urandom_range(0, 5);
        if (avail > 3) avail = 3;
      end else begin
        avail = (cycles < stall) ? 1 : 3;
      end
      bus.out_ready = rnd ? 1'($urandom % 2) : 1'b0;
      bus.insn_done = rnd ? ($urandom % 4 == 0) : 1'b0;
      drive_inputs();
      #1;
      exp_pop = (avail >= 1 && q.size() >= 1) ? ref_is_pfx(q[0]) : 1'b0;
      cap     = !exp_pop && avail >= 3 && q.size() >= 3;
      check_val("scan_pop", bus.pop, exp_pop);
      got_pop = bus.pop;
      @(posedge clk);
      if (got_pop === 1'b1 && q.size() > 0) begin
        void'(q.pop_front());
        pops++;
      end
      @(negedge clk);
      cycles++;
      check_val("scan_out_valid", bus.out_valid, cap);
    end
    if (!cap) check_val("scan_timeout", 0, 1);
    bus.out_ready = 0;
    bus.insn_done = 0;
    check_val("pop_count", pops, cur_pfx.size());
    check_summary();
  endtask

  // Holds, accepts, then retires the presented instruction
  task automatic finish_insn(input int hold);
    bus.win       = 24'h666666;
    bus.win_valid = 3'b111;
    repeat (hold) begin
      bus.out_ready = 0;
      bus.insn_done = 1'($urandom % 2);
      #1 check_val("hold_pop", bus.pop, 0);
      @(posedge clk);
      @(negedge clk);
      check_summary();
    end
    bus.insn_done = 0;
    bus.out_ready = 1;
    #1 check_val("accept_pop", bus.pop, 0);
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 0;
    check_val("accept_out_valid", bus.out_valid, 0);
    check_val("wait_prefSize", bus.prefSize, exp_cnt);
    repeat ($urandom_range(0, 2)) begin
      #1 check_val("wait_pop", bus.pop, 0);
      @(posedge clk);
      @(negedge clk);
      check_val("wait_out_valid", bus.out_valid, 0);
    end
    bus.insn_done = 1;
    #1 check_val("done_pop", bus.pop, 0);
    @(posedge clk);
    q.delete();
    @(negedge clk);
    bus.insn_done = 0;
    check_cleared("done");
  endtask

  task automatic manual_cycle(input string tag, input bit exp_pop);
    logic got_pop;
    drive_inputs();
    #1 check_val(tag, bus.pop, exp_pop);
    got_pop = bus.pop;
    @(posedge clk);
    if (got_pop === 1'b1 && q.size() > 0) void'(q.pop_front());
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    pfx_tab = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'hF3};
`ifdef PREFIX_LOCK_EN
    pfx_tab.push_back(8'hF0);
`endif
    rst = 1;
    bus.flush = 0; bus.out_ready = 0; bus.insn_done = 0;
    bus.win = 24'h892E66; bus.win_valid = 3'b111;
    avail = 3;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_pop", bus.pop, 0);
    check_val("rst_B1", bus.B1, 0);
    check_cleared("rst");
    rst = 0;

    // 66,2E then 89: two pops, capture on the third cycle
    cur_pfx = '{8'h66, 8'h2E};
    cur_ops = '{8'h89, 8'hC3, 8'h00};
    present_insn(0, 0, cyc);
    check_val("t1_latency", cyc, 3);
    check_val("t1_segSEL", bus.segSEL, 6'b000010);
    check_val("t1_B1", bus.B1, 8'h89);
    check_val("t1_prefSize", bus.prefSize, 2);
    finish_insn(0);

    // last segment override wins
    cur_pfx = '{8'h26, 8'h65, 8'hF3};
    cur_ops = '{8'h0F, 8'hAF, 8'hC3};
    present_insn(0, 0, cyc);
    check_val("t2_segSEL", bus.segSEL, 6'b100000);
    check_val("t2_isREP", bus.isREP, 1);
    check_val("t2_B123", {bus.B1, bus.B2, bus.B3}, 24'h0FAFC3);
    finish_insn(1);

    // too many prefixes, then held for 5 cycles
    cur_pfx.delete();
    repeat (6) cur_pfx.push_back(8'h66);
    cur_ops = '{8'h90, 8'h11, 8'h22};
    present_insn(0, 0, cyc);
    check_val("t3_prefSize", bus.prefSize, 6);
    check_val("t3_pref_err", bus.pref_err, 1);
    finish_insn(5);

    // partial window stall
    cur_pfx.delete();
    cur_ops = '{8'h8B, 8'h45, 8'h08};
    present_insn(4, 0, cyc);
    check_val("t4_latency", cyc, 5);
    finish_insn(0);

    // counter saturation
    cur_pfx.delete();
    repeat (17) cur_pfx.push_back(8'h66);
    cur_ops = '{8'h90, 8'h00, 8'h00};
    present_insn(0, 0, cyc);
    check_val("t5_prefSize_sat", bus.prefSize, CNT_SAT);
    finish_insn(0);

    // flush in HOLD beats a simultaneous accept
    cur_pfx = '{8'h66};
    cur_ops = '{8'h90, 8'h01, 8'h02};
    present_insn(0, 0, cyc);
    bus.flush = 1;
    bus.out_ready = 1;
    #1 check_val("flush_hold_pop", bus.pop, 0);
    @(posedge clk);
    @(negedge clk);
    bus.flush = 0;
    bus.out_ready = 0;
    check_cleared("flush_hold");
    q.delete();
    cur_pfx = '{8'h3E};
    cur_ops = '{8'h8B, 8'h07, 8'h00};
    present_insn(0, 0, cyc);
    check_val("t6_latency", cyc, 2);
    finish_insn(0);

    // flush mid-prefix forces pop low and clears the count
    q = '{8'h66, 8'h66, 8'h90, 8'h01, 8'h02};
    avail = 3;
    manual_cycle("pfx_pop", 1);
    check_val("pfx_prefSize", bus.prefSize, 1);
    bus.flush = 1;
    manual_cycle("flush_pfx_pop", 0);
    bus.flush = 0;
    check_cleared("flush_pfx");
    q.delete();

    // asynchronous reset after two pops
    q = '{8'h66, 8'h66, 8'h66, 8'h90, 8'h01, 8'h02};
    manual_cycle("arst_pop0", 1);
    manual_cycle("arst_pop1", 1);
    check_val("arst_before", bus.prefSize, 2);
    #2 rst = 1;
    #1 check_val("arst_prefSize", bus.prefSize, 0);
    check_val("arst_pop", bus.pop, 0);
    @(negedge clk);
    rst = 0;
    q.delete();

    // F0 handling depends on the lock feature
`ifdef PREFIX_LOCK_EN
    cur_pfx = '{8'hF0};
    cur_ops = '{8'hFF, 8'h06, 8'h00};
    present_insn(0, 0, cyc);
    check_val("lock_isLOCK", bus.isLOCK, 1);
    check_val("lock_B1", bus.B1, 8'hFF);
`else
    cur_pfx.delete();
    cur_ops = '{8'hF0, 8'hFF, 8'h06};
    present_insn(0, 0, cyc);
    check_val("lock_latency", cyc, 1);
    check_val("lock_B1", bus.B1, 8'hF0);
`endif
    finish_insn(0);

    // randomized instruction stream
    for (int k = 0; k < 40; k++) begin
      cur_pfx.delete();
      repeat ($urandom_range(0, 7))
        cur_pfx.push_back(pfx_tab[$urandom_range(0, pfx_tab.size() - 1)]);
      if ($urandom % 8 == 0) begin
        cur_ops[0] = 8'hF2;
      end else begin
        do cur_ops[0] = 8'($urandom); while (ref_is_pfx(cur_ops[0]));
      end
      cur_ops[1] = 8'($urandom);
      cur_ops[2] = 8'($urandom);
      present_insn(0, 1, cyc);
      finish_insn($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/prefix_strip_queue.md
Name: prefix_strip_queue

Overview:
- Sits directly upstream of the control-store overwrite stage in decode.
- Walks the head of the instruction-byte queue one byte per cycle. It pops and records x86 prefix bytes (REP, operand-size, segment overrides).
- It then snapshots the three opcode/ModRM bytes B1..B3 without popping them, and presents them with the prefix summary (isREP, isSIZE, isSEG, segSEL, prefSize) over a valid/ready handshake.
- The downstream length decoder later pops the opcode bytes and signals completion.

Parameters:
- MAX_PFX, 4, legal prefix count; a prefix beyond this sets pref_err.
- CNT_W, 4, width of prefSize counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- win  in  24  queue head window; win[7:0]=byte0, win[15:8]=byte1, win[23:16]=byte2
- win_valid  in  3  per-byte valid for win
- pop  out  1  pop one byte from queue head this cycle
- flush  in  1  redirect; abort current insn
- out_valid  out  1  snapshot valid
- out_ready  in  1  downstream accepts
- insn_done  in  1  downstream has popped opcode bytes; start next insn
- B1, B2, B3  out  8 each  opcode bytes (byte0..byte2 at capture)
- isREP  out  1  0xF3 seen
- isSIZE  out  1  0x66 seen
- isSEG  out  1  segment override seen
- segSEL  out  6  one-hot segment: bit0 ES(26) bit1 CS(2E) bit2 SS(36) bit3 DS(3E) bit4 FS(64) bit5 GS(65)
- prefSize  out  CNT_W  number of prefix bytes popped
- pref_err  out  1  more than MAX_PFX prefixes
- isLOCK  out  1  only with PREFIX_LOCK_EN; 0xF0 seen

Behaviour:
- Reset (async, any state): state=PFX; all outputs 0, including pop, out_valid, B1-3, flags, segSEL, prefSize, pref_err.
- States: PFX, HOLD, WAIT.
- PFX:
  - pop = win_valid[0] & is_prefix(win[7:0]). pop is combinational from state and window.
  - On a pop:
    - F3 sets isREP; 66 sets isSIZE.
    - A segment byte sets isSEG and replaces segSEL; the last override wins.
    - prefSize increments, saturating.
    - pref_err sets when the incremented count exceeds MAX_PFX. Popping continues regardless.
    - Duplicate prefixes count again; their flags stay 1.
  - Non-prefix byte0 with win_valid==3'b111: capture B1..B3 <= win bytes 0..2, no pop, go HOLD, out_valid=1 next cycle.
  - Non-prefix byte0 with any win_valid bit 0: stall in PFX, no pop.
  - F2 and all other bytes are non-prefix.
- HOLD: out_valid=1. All outputs stable until out_valid & out_ready, then go WAIT with out_valid=0 next cycle.
- WAIT: pop=0.
  - insn_done: clear flags, segSEL, prefSize, pref_err; go PFX.
  - insn_done in PFX or HOLD is ignored.
- flush (synchronous, highest priority, any state): next cycle state=PFX with all summary outputs cleared. pop is forced 0 in the flush cycle.
- Handshake rules:
  - Accept in the same cycle as flush is discarded; flush wins.
  - out_valid never drops without accept or flush.
- Latency:
  - Prefix-free insn: captured the cycle it is presented; out_valid one cycle later.
  - n prefixes add n cycles.
- B1..B3 are undefined-but-stable across prefixes; they are only meaningful while out_valid.

Optional Feature:
- Macro PREFIX_LOCK_EN.
- Defined: 0xF0 is a prefix. It is popped, counted, sets isLOCK, and isLOCK clears with the other flags. The isLOCK port exists.
- Undefined: 0xF0 is an opcode byte captured into B1. The isLOCK port is absent.

Test Plan:
- Window 66,2E,89 with all valid; out_ready=1:
  - Pops in cycles 0-1; capture in cycle 2.
  - Snapshot: B1=89, isSIZE=1, isSEG=1, segSEL=000010, prefSize=2, pref_err=0.
- Prefix stream 26,65,F3 then 0F,AF,C3:
  - segSEL=100000 (last wins), isREP=1, prefSize=3.
  - B1=0F, B2=AF, B3=C3.
- Six 66 bytes then 90:
  - prefSize=6, pref_err=1, isSIZE=1.
  - out_valid held with out_ready=0 for 5 cycles; outputs stable throughout.
- Byte0=8B with win_valid=001 for 4 cycles, then 111:
  - No pop and no out_valid during the stall.
  - Capture on the first 111 cycle.
- flush:
  - In HOLD: next cycle out_valid=0 and prefSize=0.
  - rst asserted mid-PFX after 2 pops: prefSize=0 immediately (async).
- PREFIX_LOCK_EN compare, window F0,FF,06:
  - Defined: pop, isLOCK=1, B1=FF.
  - Undefined: no pop, B1=F0.
